// File: rtl/locked_priority_arbiter.sv
// locked_priority_arbiter
//   Fixed-priority arbiter (port 0 highest) that locks a registered grant
//   across a multi-cycle transaction. Ownership ends on done_i, on owner
//   request withdrawal, or (optionally) on a hold-limit timeout. Releases
//   with done_i or timeout mask the releasing port for that one
//   re-arbitration only. Re-arbitration happens on the release edge, so
//   there is no idle bubble between owners.
//
//   Optional feature: define ARB_HOLD_LIMIT_EN to compile in hold_cnt and
//   the MAX_HOLD timeout release.
//
// Parameters:
//   NUM_PORTS  number of requesters (2..16)
//   MAX_HOLD   max consecutive grant cycles with the hold limit (1..255)
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   req_i     per-port level request, held for the whole transaction
//   done_i    owner's last cycle of use; ignored when idle
//   gnt_o     registered one-hot grant, zero when idle
//   gnt_id_o  binary index of the granted port, zero when idle
//   busy_o    high while any grant is active
module locked_priority_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic                         done_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_id_o,
  output logic                         busy_o
);

  localparam int ID_W = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_cfg
    $error("locked_priority_arbiter: NUM_PORTS or MAX_HOLD out of range");
  end

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic                  busy_q;

  logic                  owner_req;
  logic                  timeout;
  logic                  new_grant;
  logic                  rearb;
  logic [NUM_PORTS-1:0]  mask;
  logic [NUM_PORTS-1:0]  cand;
  logic [ID_W-1:0]       pick_id;
  logic                  found;

  assign owner_req = |(req_i & gnt_q);

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q;

  // hold_q counts completed cycles of the current ownership; the timeout
  // fires during the MAX_HOLD-th cycle, so the count never needs to wrap.
  assign timeout = (state_q == OWNED) && (hold_q == HOLD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || new_grant) begin
      hold_q <= '0;
    end else if (state_q == OWNED && hold_q != HOLD_LAST) begin
      hold_q <= hold_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    mask      = '0;
    rearb     = 1'b0;
    new_grant = 1'b0;
    cand      = '0;
    pick_id   = '0;
    found     = 1'b0;

    case (state_q)
      IDLE: rearb = 1'b1;
      OWNED: begin
        // done_i takes precedence over both req drop and timeout.
        if (done_i) begin
          rearb = 1'b1;
          mask  = gnt_q;
        end else if (!owner_req) begin
          rearb = 1'b1;
        end else if (timeout) begin
          rearb = 1'b1;
          mask  = gnt_q;
        end
      end
      default: rearb = 1'b1;
    endcase

    cand = req_i & ~mask;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (cand[i] && !found) begin
        pick_id = ID_W'(i);
        found   = 1'b1;
      end
    end

    if (rearb) begin
      if (found) begin
        state_d   = OWNED;
        gnt_d     = NUM_PORTS'(1) << pick_id;
        id_d      = pick_id;
        new_grant = 1'b1;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      busy_q  <= |gnt_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign gnt_id_o = id_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_locked_priority_arbiter.sv
// Directed testbench for locked_priority_arbiter (NUM_PORTS=4).
// With ARB_HOLD_LIMIT_EN defined the DUT is built with MAX_HOLD=3 and the
// timeout rotation is checked; otherwise the unbounded hold is checked.
module tb_locked_priority_arbiter;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int MH = 3;
`else
  localparam int MH = 8;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  locked_priority_arbiter #(
    .NUM_PORTS (4),
    .MAX_HOLD  (MH)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .done_i   (done),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .busy_o   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_id);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".id"}, 32'(gnt_id), 32'(exp_id));
    check({tag, ".busy"}, 32'(busy), 32'(exp_gnt != 4'b0000));
  endtask

`ifdef ARB_HOLD_LIMIT_EN
  logic [3:0] rot_gnt [12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                               4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
`endif

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;
    tick();
    tick();
    check_grant("reset", 4'b0000, 2'd0);

    // First grant, then no preemption by higher-priority port 0.
    rst = 1'b0;
    req = 4'b1010;
    tick();
    check_grant("first_grant", 4'b0010, 2'd1);
    req = 4'b1011;
    tick();
    check_grant("no_preempt", 4'b0010, 2'd1);

    // done_i hands over directly to port 2, then request drop idles.
    done = 1'b1;
    req  = 4'b0110;
    tick();
    check_grant("handover", 4'b0100, 2'd2);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    check_grant("drop_idle", 4'b0000, 2'd0);

    // Sole requester finishing with req held: one masked idle cycle.
    req = 4'b0100;
    tick();
    check_grant("sole_grant", 4'b0100, 2'd2);
    done = 1'b1;
    tick();
    check_grant("sole_masked", 4'b0000, 2'd0);
    done = 1'b0;
    tick();
    check_grant("sole_regrant", 4'b0100, 2'd2);

    // Reset in the middle of an ownership.
    req = 4'b1111;
    rst = 1'b1;
    tick();
    check_grant("mid_reset", 4'b0000, 2'd0);
    rst = 1'b0;
    tick();
    check_grant("post_reset", 4'b0001, 2'd0);
    req = 4'b0000;
    tick();
    check_grant("idle_again", 4'b0000, 2'd0);

`ifdef ARB_HOLD_LIMIT_EN
    // Two constant requesters rotate every MAX_HOLD=3 cycles.
    req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_grant($sformatf("rot%0d", i), rot_gnt[i], (rot_gnt[i] == 4'b0010) ? 2'd1 : 2'd0);
    end
`else
    // Without a hold limit port 0 keeps the grant indefinitely.
    req = 4'b0011;
    for (int i = 0; i < 110; i++) begin
      tick();
      check($sformatf("hold%0d", i), 32'(gnt), 32'h1);
    end
    req = 4'b0010;
    tick();
    check_grant("hold_drop", 4'b0010, 2'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/locked_priority_arbiter.md
# locked_priority_arbiter

Sequential fixed-priority arbiter that grants a shared resource to one of NUM_PORTS requesters and holds (locks) the grant across a multi-cycle transaction. Port 0 has highest priority. The grant is registered. It is released on owner completion, on owner request withdrawal, or optionally on a hold-limit timeout. The block sits in front of any shared datapath (bus, memory port, engine) whose users need ownership for more than one cycle.

## Interface
- NUM_PORTS, 4, number of requesters; legal range 2..16
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership when the hold limit is compiled in; legal range 1..255
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- req_i  input  NUM_PORTS  request per port; level, held for the whole transaction
- done_i  input  1  current owner signals its last cycle of use; ignored when no grant is active
- gnt_o  output  NUM_PORTS  registered one-hot grant, all-zero when idle
- gnt_id_o  output  $clog2(NUM_PORTS)  binary index of the granted port; 0 when idle
- busy_o  output  1  high while any grant is active (equals |gnt_o)

## Operation
- States: IDLE (no grant) and OWNED (one grant locked).
- IDLE:
  - If |req_i, register the lowest-index requester into gnt_o and gnt_id_o, clear hold_cnt, and go to OWNED.
  - Otherwise stay in IDLE.
- OWNED: the grant is held unchanged while req_i[owner]=1, done_i=0 and no timeout occurs; hold_cnt increments each cycle.
- Release events, evaluated in OWNED:
  - done_i=1: releasing port is masked.
  - req_i[owner]=0: no mask needed.
  - Timeout, hold_cnt==MAX_HOLD-1 (hold limit only): releasing port is masked.
- On a release cycle, re-arbitrate using req_i & ~mask.
  - If any masked request remains, grant the lowest-index one next cycle, reset hold_cnt, and stay OWNED. No idle bubble.
  - Else go to IDLE with gnt_o=0 next cycle.
- The mask applies to that single arbitration only; nothing is remembered afterwards.
- Simultaneous done_i and timeout are treated as done_i. Simultaneous done_i and owner req drop are treated as done_i; the outcome is identical.
- Requests from non-owners never preempt, including higher-priority ports.
- hold_cnt width is $clog2(MAX_HOLD+1). It saturates and never wraps, because a timeout always fires first.
- gnt_o is always one-hot or zero. gnt_id_o is always consistent with gnt_o.

## Timing
- Reset values: gnt_o=0, gnt_id_o=0, busy_o=0, state=IDLE, hold_cnt=0.
- Requests sampled in the reset cycle are ignored.
- Reset asserted mid-ownership: grant is 0 in the cycle after the reset edge. Arbitration resumes on the first edge with rst_i=0.
- Request-to-grant latency: 1 cycle (req_i sampled at edge N, gnt_o valid after edge N).
- Release-to-next-grant latency: 1 cycle. The new owner's gnt_o replaces the old one on the same edge.
- Maximum ownership with the hold limit: exactly MAX_HOLD cycles of gnt_o high.
- MAX_HOLD=1 yields a new arbitration every cycle, with the previous owner masked.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.

## Configuration
- ARB_HOLD_LIMIT_EN defined:
  - hold_cnt and the timeout release are compiled in.
  - Ownership is bounded by MAX_HOLD.
  - The timed-out port is masked for one arbitration.
- ARB_HOLD_LIMIT_EN undefined:
  - No hold_cnt and no timeout; MAX_HOLD is unused.
  - Ownership ends only on done_i or owner req drop.
  - A port that never asserts done_i and never drops req holds the resource indefinitely.

## Test plan
- Reset then req_i=4'b1010 steady -> cycle after the first post-reset edge: gnt_o=4'b0010, gnt_id_o=1, busy_o=1. Grant stays fixed after req_i[0] also rises (no preemption).
- Owner port 1 pulses done_i with req_i=4'b0110 -> next cycle gnt_o=4'b0100 with no idle cycle. Then req_i=0 -> gnt_o=0 and busy_o=0 one cycle later.
- ARB_HOLD_LIMIT_EN, MAX_HOLD=3, req_i=4'b0011 constant, done_i=0:
  - Port 0 is granted for exactly 3 cycles, then port 1 for 3 cycles, then port 0 again.
  - The pattern repeats.
- Without ARB_HOLD_LIMIT_EN, same stimulus -> port 0 holds the grant for 100+ cycles. Owner drops req -> port 1 is granted next cycle.
- rst_i asserted during an ownership with req_i=4'b1111 -> gnt_o=0 in the cycle after reset. On the first edge after rst_i deasserts, gnt_o=4'b0001.
- Sole requester port 2 asserts done_i while keeping req_i[2]=1 -> one cycle of gnt_o=0 (masked), then gnt_o=4'b0100 again.
